// File: rtl/md5_padder.sv
// MD5 message padder: packs a byte stream into 512-bit blocks, appends 0x80, zero fill and 64-bit LE bit length.
// Latency: a block is offered to the core one cycle after its last byte (two when padding is inserted); strobe one cycle after core_ready.
// Backpressure: in_ready drops while a block is being sent/padded; each block is held stable until the core reports ready again.
module md5_padder #(
  parameter int CNT_WIDTH = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    PAD  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t               state;
  logic [7:0]           blk [64];
  logic [7:0]           pad_byte [64];
  logic [5:0]           idx;
  logic [CNT_WIDTH-1:0] byte_cnt;
  logic                 first_flag;
  logic [1:0]           pad_pending;  // 0: none, 1: full data block sent, 2: length-only block owed
  logic [5:0]           pad_n;        // byte position where 0x80 goes
  logic                 final_blk;
  logic                 wait_first;
  logic                 sent;         // strobe issued, leaving SEND next edge

  logic                 accept;
  logic                 store_byte;
  logic [63:0]          bit_len;
  logic [5:0]           pad_pos;
  logic                 len_fits;

  assign accept     = in_valid && in_ready;
  // A last beat flagged empty carries no byte; in_empty means nothing on other beats.
  assign store_byte = !(in_last && in_empty);
  assign bit_len    = 64'(byte_cnt) << 3;
  assign pad_pos    = (pad_pending == 2'd1) ? 6'd0 : pad_n;
  assign len_fits   = (pad_pos <= 6'd55);
  assign busy       = (state != IDLE);

  // Build the padded image of the buffer that PAD will commit.
  always_comb begin
    for (int j = 0; j < 64; j++) pad_byte[j] = blk[j];
    if (pad_pending == 2'd2) begin
      for (int j = 0; j < 64; j++) pad_byte[j] = 8'h00;
      for (int k = 0; k < 8; k++) pad_byte[56+k] = bit_len[8*k +: 8];
    end else begin
      for (int j = 0; j < 64; j++) begin
        if (j == int'(pad_pos))     pad_byte[j] = 8'h80;
        else if (j > int'(pad_pos)) pad_byte[j] = 8'h00;
      end
      if (len_fits) begin
        for (int k = 0; k < 8; k++) pad_byte[56+k] = bit_len[8*k +: 8];
      end
    end
  end

  // Map buffer bytes onto core words: word i little-endian, word 0 at the top.
  always_comb begin
    core_block = '0;
    for (int i = 0; i < 16; i++) begin
      core_block[511-32*i -: 32] = {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
    end
  end

  // Main FSM with registered strobes, in_ready and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      done        <= 1'b0;
      for (int j = 0; j < 64; j++) blk[j] <= 8'h00;
      idx         <= 6'd0;
      byte_cnt    <= '0;
      first_flag  <= 1'b1;
      pad_pending <= 2'd0;
      pad_n       <= 6'd0;
      final_blk   <= 1'b0;
      wait_first  <= 1'b0;
      sent        <= 1'b0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE, FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            state <= FILL;
            if (store_byte) begin
              blk[idx] <= in_data;
              idx      <= idx + 6'd1;
              byte_cnt <= byte_cnt + CNT_WIDTH'(1);
            end
            if (in_last) begin
              pad_n    <= store_byte ? idx + 6'd1 : idx;
              in_ready <= 1'b0;
              if (store_byte && idx == 6'd63) begin
                // Data exactly fills the block: send it, then a pad-only block.
                state       <= SEND;
                pad_pending <= 2'd1;
                final_blk   <= 1'b0;
                sent        <= 1'b0;
              end else begin
                state <= PAD;
              end
            end else if (idx == 6'd63) begin
              state       <= SEND;
              pad_pending <= 2'd0;
              final_blk   <= 1'b0;
              sent        <= 1'b0;
              in_ready    <= 1'b0;
            end
          end
        end
        PAD: begin
          for (int j = 0; j < 64; j++) blk[j] <= pad_byte[j];
          final_blk   <= (pad_pending == 2'd2) ? 1'b1 : len_fits;
          pad_pending <= (pad_pending != 2'd2 && !len_fits) ? 2'd2 : 2'd0;
          sent        <= 1'b0;
          state       <= SEND;
        end
        SEND: begin
          if (sent) begin
            sent       <= 1'b0;
            wait_first <= 1'b1;
            state      <= WAIT;
          end else if (core_ready) begin
            core_init  <= first_flag;
            core_next  <= !first_flag;
            first_flag <= 1'b0;
            sent       <= 1'b1;
          end
        end
        WAIT: begin
          // The core may still show ready on the cycle after the strobe.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (core_ready) begin
            if (final_blk) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (pad_pending != 2'd0) begin
              state <= PAD;
            end else begin
              for (int j = 0; j < 64; j++) blk[j] <= 8'h00;
              idx      <= 6'd0;
              in_ready <= 1'b1;
              state    <= FILL;
            end
          end
        end
        DONE: begin
          byte_cnt    <= '0;
          first_flag  <= 1'b1;
          idx         <= 6'd0;
          pad_pending <= 2'd0;
          final_blk   <= 1'b0;
          for (int j = 0; j < 64; j++) blk[j] <= 8'h00;
          in_ready    <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_padder.sv
// Directed bench for md5_padder: table of message lengths with hand-computed block words,
// plus hand-written sequences for reset values, a stalled core and reset during WAIT.
// A small core model drops core_ready for a few cycles after each strobe.
module tb_md5_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_ready;
  logic         busy;
  logic         done;

  md5_padder #(.CNT_WIDTH(61)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .core_init (core_init),
    .core_next (core_next),
    .core_block(core_block),
    .core_ready(core_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Core model and strobe monitor.
  logic [511:0] blks [$];
  int n_init = 0;
  int n_next = 0;
  int n_done = 0;
  int rdy_wait = 0;
  bit hold = 1'b0;
  bit both_hi = 1'b0;

  assign core_ready = !hold && (rdy_wait == 0);

  always @(negedge clk) begin
    if (core_init && core_next) both_hi = 1'b1;
    if (core_init || core_next) begin
      blks.push_back(core_block);
      rdy_wait = 4;
      if (core_init) n_init++;
      else           n_next++;
    end else if (rdy_wait > 0) begin
      rdy_wait--;
    end
    if (done) n_done++;
  end

  typedef struct {
    int          len;
    int          nblk;
    bit          zmid;   // words 1..13 of the last block must be zero
    logic [31:0] w0f, w14f, w15f;
    logic [31:0] w0l, w14l, w15l;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] word(input logic [511:0] b, input int i);
    return b[511-32*i -: 32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    blks.delete();
    n_init = 0;
    n_next = 0;
    n_done = 0;
    both_hi = 1'b0;
  endtask

  // Present one beat at a negedge and hold it until it has been accepted.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_empty = e;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got in_ready=0 expected 1 within 5000 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  // Message byte k is 0x61+k; non-last beats carry in_empty=1, which must be ignored.
  task automatic send_msg(input int len, input bit with_last);
    if (len == 0) begin
      send_beat(8'h00, 1'b1, 1'b1);
    end else begin
      for (int k = 0; k < len; k++) begin
        send_beat(8'(8'h61 + k), with_last && (k == len - 1), !(with_last && (k == len - 1)));
      end
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (n_done == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_seen"}, 64'(n_done != 0), 64'(1));
    @(negedge clk);
    chk({name, "_done_width"}, 64'(done), 64'(0));
    repeat (8) @(negedge clk);
    chk({name, "_done_count"}, 64'(n_done), 64'(1));
    chk({name, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    //           len nblk zmid  w0f           w14f          w15f          w0l           w14l          w15l
    vecs[0] = '{0,   1, 1'b1, 32'h00000080, 32'h00000000, 32'h00000000, 32'h00000080, 32'h00000000, 32'h00000000};
    vecs[1] = '{3,   1, 1'b1, 32'h80636261, 32'h00000018, 32'h00000000, 32'h80636261, 32'h00000018, 32'h00000000};
    vecs[2] = '{55,  1, 1'b0, 32'h64636261, 32'h000001B8, 32'h00000000, 32'h64636261, 32'h000001B8, 32'h00000000};
    vecs[3] = '{56,  2, 1'b1, 32'h64636261, 32'h00000080, 32'h00000000, 32'h00000000, 32'h000001C0, 32'h00000000};
    vecs[4] = '{63,  2, 1'b1, 32'h64636261, 32'h9C9B9A99, 32'h809F9E9D, 32'h00000000, 32'h000001F8, 32'h00000000};
    vecs[5] = '{64,  2, 1'b1, 32'h64636261, 32'h9C9B9A99, 32'hA09F9E9D, 32'h00000080, 32'h00000200, 32'h00000000};
    vecs[6] = '{120, 3, 1'b0, 32'h64636261, 32'h9C9B9A99, 32'hA09F9E9D, 32'h00000000, 32'h000003C0, 32'h00000000};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_empty = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy",     64'(busy),     64'(0));
    chk("rst_done",     64'(done),     64'(0));
    chk("rst_strobes",  64'({core_init, core_next}), 64'(0));
    chk("rst_block_lo", core_block[63:0],    64'(0));
    chk("rst_block_hi", core_block[511:448], 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // Table-driven messages.
    for (int v = 0; v < 7; v++) begin
      string nm;
      nm = $sformatf("len%0d", vecs[v].len);
      clear_mon();
      send_msg(vecs[v].len, 1'b1);
      wait_done(nm);
      chk({nm, "_nblk"},  64'(blks.size()), 64'(vecs[v].nblk));
      chk({nm, "_ninit"}, 64'(n_init), 64'(1));
      chk({nm, "_nnext"}, 64'(n_next), 64'(vecs[v].nblk - 1));
      if (blks.size() > 0) begin
        chk({nm, "_w0_first"},  64'(word(blks[0], 0)),  64'(vecs[v].w0f));
        chk({nm, "_w14_first"}, 64'(word(blks[0], 14)), 64'(vecs[v].w14f));
        chk({nm, "_w15_first"}, 64'(word(blks[0], 15)), 64'(vecs[v].w15f));
        chk({nm, "_w0_last"},   64'(word(blks[blks.size()-1], 0)),  64'(vecs[v].w0l));
        chk({nm, "_w14_last"},  64'(word(blks[blks.size()-1], 14)), 64'(vecs[v].w14l));
        chk({nm, "_w15_last"},  64'(word(blks[blks.size()-1], 15)), 64'(vecs[v].w15l));
        if (vecs[v].zmid) begin
          for (int i = 1; i < 14; i++) begin
            chk($sformatf("%s_w%0d_last", nm, i), 64'(word(blks[blks.size()-1], i)), 64'(0));
          end
        end
      end
      chk({nm, "_mutex"}, 64'(both_hi), 64'(0));
    end

    // Core stalled for 100 cycles while a block waits in SEND.
    begin
      logic [511:0] held;
      bit strobe_seen, rdy_seen, blk_moved;
      clear_mon();
      hold = 1'b1;
      send_msg(3, 1'b1);
      repeat (2) @(negedge clk);
      held = core_block;
      strobe_seen = 1'b0;
      rdy_seen = 1'b0;
      blk_moved = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (core_init || core_next) strobe_seen = 1'b1;
        if (in_ready) rdy_seen = 1'b1;
        if (core_block !== held) blk_moved = 1'b1;
        @(negedge clk);
      end
      chk("stall_no_strobe", 64'(strobe_seen), 64'(0));
      chk("stall_in_ready",  64'(rdy_seen),    64'(0));
      chk("stall_block",     64'(blk_moved),   64'(0));
      chk("stall_busy",      64'(busy),        64'(1));
      hold = 1'b0;
      @(negedge clk);
      chk("stall_strobe_next", 64'(core_init), 64'(1));
      wait_done("stall");
      chk("stall_ninit", 64'(n_init), 64'(1));
      if (blks.size() > 0) begin
        chk("stall_w0",  64'(word(blks[0], 0)),  64'(32'h80636261));
        chk("stall_w14", 64'(word(blks[0], 14)), 64'(32'h00000018));
      end
    end

    // Reset during WAIT of the first block of a 100-byte message.
    begin
      int t;
      clear_mon();
      send_msg(64, 1'b0);
      t = 0;
      while (!core_init && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("rstwait_init_seen", 64'(core_init), 64'(1));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstwait_busy",     64'(busy), 64'(0));
      chk("rstwait_strobes",  64'({core_init, core_next}), 64'(0));
      chk("rstwait_in_ready", 64'(in_ready), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("rstwait_idle_rdy",  64'(in_ready), 64'(1));
      chk("rstwait_idle_busy", 64'(busy), 64'(0));
      repeat (6) @(negedge clk);
      clear_mon();
      send_msg(3, 1'b1);
      wait_done("after_rst");
      chk("after_rst_ninit", 64'(n_init), 64'(1));
      chk("after_rst_nnext", 64'(n_next), 64'(0));
      if (blks.size() > 0) begin
        chk("after_rst_w0",  64'(word(blks[0], 0)),  64'(32'h80636261));
        chk("after_rst_w14", 64'(word(blks[0], 14)), 64'(32'h00000018));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md5_padder.md
Name: md5_padder

Overview:
- Upstream feeder for the MD5 hash core: accepts a byte stream, applies MD5 padding (0x80, zero fill, 64-bit little-endian bit length) and presents complete 512-bit blocks to the core.
- Drives the core's init/next strobes and holds each block stable until the core reports ready again.
- Pulses done once the final block of a message has been absorbed.
- Sits between the message source (DMA/bus FIFO) and the core's block/init/next/ready interface.

Parameters:
- CNT_WIDTH, 61, width of the message byte counter; length field = {byte_cnt, 3'b000} zero-extended to 64 bits. Maximum message is 2^CNT_WIDTH-1 bytes; the counter wraps modulo 2^CNT_WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  padder can accept a beat
- in_data  input  8  message byte
- in_last  input  1  beat is the final beat of the message
- in_empty  input  1  qualifies in_last: the beat carries no byte (zero-length tail, needed for empty messages); ignored when in_last=0
- core_init  output  1  one-cycle strobe: first block of a message
- core_next  output  1  one-cycle strobe: subsequent block
- core_block  output  512  block to core; word i at [511-32i -: 32]; word i = {byte[4i+3], byte[4i+2], byte[4i+1], byte[4i]}
- core_ready  input  1  core idle / finished previous block
- busy  output  1  a message is in progress (state != IDLE)
- done  output  1  one-cycle pulse after the final block has been processed

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: in_ready=0 for the reset cycle, then 1 in IDLE. core_init=0, core_next=0, busy=0, done=0. Block buffer, byte index and byte counter cleared. first_flag=1.
- Transfer rule: a beat transfers when in_valid && in_ready. in_ready=1 only in IDLE and FILL.
- States: IDLE, FILL, SEND, WAIT, PAD, DONE.
- IDLE/FILL:
  - A data beat writes byte[idx], increments idx (0..63) and the byte counter. IDLE moves to FILL on the first transfer.
  - When idx wraps 63→0 on a non-last beat: go to SEND with pad_pending=0.
  - On a last beat, after storing any byte (none if in_empty), let n = new idx. n=0 is possible when the last byte fills the block. Record n and go to SEND if n==0 (full data block first, pad_pending=1), else go to PAD.
- PAD (1 cycle), with position n:
  - byte[n]=0x80 and bytes n+1..63 = 0.
  - If n<=55: bytes 56..63 = 64-bit bit length, LSB first; this block is final.
  - Else: this block is non-final, and a following length-only block is needed (pad_pending=2).
  - Then go to SEND.
- pad_pending=1 (full data block just sent): the next PAD uses n=0, giving a final block with 0x80 at byte 0 and the length.
- pad_pending=2: the next PAD builds an all-zero block with the length in bytes 56..63 and no 0x80. This block is final.
- SEND:
  - Wait for core_ready=1.
  - Then assert core_init (if first_flag) or core_next for exactly one cycle, clear first_flag, and go to WAIT.
  - core_block is never modified from SEND entry until WAIT exit.
- WAIT:
  - The first WAIT cycle ignores core_ready.
  - Afterwards, on core_ready=1: if the block was final, go to DONE. Else if pad_pending, go to PAD. Else clear the buffer, set idx=0, and go to FILL.
- DONE: done=1 for one cycle. Clear the counter, set first_flag=1, go to IDLE.
- core_init and core_next are never high simultaneously and are never high outside SEND.
- Reset asserted in any state (including SEND/WAIT) returns to reset values on the next edge. The partial message is discarded; no strobe is issued in that cycle.
- in_valid with in_last=0 and in_empty=1: in_empty is ignored and the byte is stored.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) → one core_init pulse. word0=0x80636261, words1..13=0, word14=0x00000018, word15=0. Then done pulse. No core_next.
- Empty message (single beat, in_last=1, in_empty=1) → one core_init. word0=0x00000080, all other words 0 (length 0). Then done.
- 56-byte message → core_init with block 1 = data + 0x80 at byte 56, rest zero. Then core_next with block 2 = zeros except word14=0x000001C0.
- 64-byte message → core_init with the full data block, then core_next with word0=0x00000080, word14=0x00000200, other words 0.
- core_ready held low for 100 cycles in SEND → no strobe, in_ready=0, core_block constant. Strobe appears the cycle after core_ready rises.
- Reset pulsed during WAIT of the first block of a 100-byte message → next cycle: IDLE, busy=0, no strobe, in_ready=1. A following "abc" then produces the expected single init block with word14=0x18.
